// File: rtl/four_two_encoder_pkg.sv
// Shared types and helpers for the debounced 4:2 priority encoder.
// Holds the FSM state encoding, counter width and the encode function.
package four_two_encoder_pkg;

  localparam int unsigned CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    HOLD    = 2'd2,
    RELEASE = 2'd3
  } state_e;

  typedef struct packed {
    logic [1:0] code;
    logic       multi;
  } enc_t;

  // Highest set bit wins; multi flags any request with more than one bit set.
  function automatic enc_t encode4(input logic [3:0] v);
    enc_t r;
    r = '0;
    if (v[3]) begin
      r.code = 2'd3;
    end else if (v[2]) begin
      r.code = 2'd2;
    end else if (v[1]) begin
      r.code = 2'd1;
    end else begin
      r.code = 2'd0;
    end
    r.multi = ((v & (v - 4'd1)) != 4'd0);
    return r;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for an asynchronous multi-bit level input.
// Bits are synchronized independently; the FSM debounce absorbs any skew.
module sync_2ff #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/four_two_encoder_sync.sv
// Debounced 4:2 priority encoder with a valid/ready event output.
// Define ENC_INPUT_SYNC_EN to pass d through a two-flop synchronizer first.
module four_two_encoder_sync
  import four_two_encoder_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] d,
  output logic [1:0] y_code,
  output logic       y_valid,
  input  logic       y_ready,
  output logic       multi_hot
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [3:0] w_d_s;

`ifdef ENC_INPUT_SYNC_EN
  sync_2ff #(
    .WIDTH (4)
  ) u_sync_2ff (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   (d),
    .o_q   (w_d_s)
  );
`else
  assign w_d_s = d;
`endif

  state_e           r_state;
  state_e           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [3:0]       r_ref;
  logic [3:0]       w_ref_nxt;
  logic             w_valid_nxt;
  logic [1:0]       w_code_nxt;
  logic             w_multi_nxt;
  enc_t             w_enc;

  assign w_enc = encode4(r_ref);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_ref_nxt   = r_ref;
    w_valid_nxt = y_valid;
    w_code_nxt  = y_code;
    w_multi_nxt = multi_hot;

    unique case (r_state)
      IDLE: begin
        if (w_d_s != 4'd0) begin
          w_ref_nxt   = w_d_s;
          w_cnt_nxt   = '0;
          w_state_nxt = SETTLE;
        end
      end

      SETTLE: begin
        if (w_d_s == 4'd0) begin
          w_state_nxt = IDLE;
        end else if (w_d_s != r_ref) begin
          w_ref_nxt = w_d_s;
          w_cnt_nxt = '0;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt = HOLD;
          w_valid_nxt = 1'b1;
          w_code_nxt  = w_enc.code;
          w_multi_nxt = w_enc.multi;
        end else begin
          w_cnt_nxt = r_cnt + CNT_ONE;
        end
      end

      // Outputs frozen until the consumer takes the event; d is ignored here.
      HOLD: begin
        if (y_ready) begin
          w_valid_nxt = 1'b0;
          w_cnt_nxt   = '0;
          w_state_nxt = RELEASE;
        end
      end

      // Re-arm only after d has read zero for STABLE_CYCLES samples in a row.
      RELEASE: begin
        if (w_d_s != 4'd0) begin
          w_cnt_nxt = '0;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt = IDLE;
        end else begin
          w_cnt_nxt = r_cnt + CNT_ONE;
        end
      end

      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_ref     <= '0;
      y_valid   <= 1'b0;
      y_code    <= 2'b00;
      multi_hot <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_ref     <= w_ref_nxt;
      y_valid   <= w_valid_nxt;
      y_code    <= w_code_nxt;
      multi_hot <= w_multi_nxt;
    end
  end

endmodule

// File: tb/tb_four_two_encoder_sync.sv
// Scoreboard bench for four_two_encoder_sync: a run-length reference model
// predicts events, a negedge monitor pops and compares them.
module tb_four_two_encoder_sync;

  localparam int unsigned STABLE = 4;
`ifdef ENC_INPUT_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif
  localparam int RISE = STABLE + 1 + LAT;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] d;
  logic       y_ready;
  logic [1:0] y_code;
  logic       y_valid;
  logic       multi_hot;

  four_two_encoder_sync #(
    .STABLE_CYCLES (STABLE)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .d         (d),
    .y_code    (y_code),
    .y_valid   (y_valid),
    .y_ready   (y_ready),
    .multi_hot (multi_hot)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  typedef struct {
    logic [1:0] code;
    logic       multi;
    int         cyc;
  } ev_t;
  ev_t exp_q[$];

  task automatic check(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference model: an event fires once a run of identical nonzero samples
  // reaches STABLE+1 while armed; re-arming needs STABLE zero samples after accept.
  logic [3:0] m_p1, m_p2, m_prev;
  int         m_phase;  // 0 armed, 1 holding, 2 re-arming
  int         m_run, m_zrun;
  logic       m_valid;
  logic [1:0] m_code;
  logic       m_multi;

  initial begin
    logic [3:0] s;
    ev_t        e;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_p1 = '0; m_p2 = '0; m_prev = '0;
        m_phase = 0; m_run = 0; m_zrun = 0;
        m_valid = 1'b0; m_code = 2'b00; m_multi = 1'b0;
        exp_q.delete();
      end else begin
        cyc++;
        s = (LAT == 2) ? m_p2 : d;
        m_p2 = m_p1;
        m_p1 = d;
        case (m_phase)
          0: begin
            if (s == 4'd0) m_run = 0;
            else if (s == m_prev) m_run++;
            else m_run = 1;
            m_prev = s;
            if (m_run == STABLE + 1) begin
              e.code = 2'd0;
              for (int i = 0; i < 4; i++) if (s[i]) e.code = 2'(i);
              e.multi = ($countones(s) > 1);
              e.cyc = cyc;
              exp_q.push_back(e);
              m_valid = 1'b1; m_code = e.code; m_multi = e.multi;
              m_phase = 1;
            end
          end
          1: begin
            if (y_ready) begin
              m_valid = 1'b0; m_zrun = 0; m_phase = 2;
            end
          end
          default: begin
            if (s != 4'd0) m_zrun = 0;
            else m_zrun++;
            if (m_zrun == STABLE) begin
              m_phase = 0; m_run = 0; m_prev = '0;
            end
          end
        endcase
      end
    end
  end

  // Monitor
  int         n_rise = 0;
  int         last_rise_cyc = 0;
  logic [1:0] last_code = 2'b00;
  logic       last_multi = 1'b0;
  logic       prev_valid = 1'b0;

  initial begin
    ev_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_valid = 1'b0;
      end else begin
        check("y_valid", y_valid, m_valid);
        check("y_code", y_code, m_code);
        check("multi_hot", multi_hot, m_multi);
        if (y_valid && !prev_valid) begin
          n_rise++;
          last_rise_cyc = cyc;
          last_code = y_code;
          last_multi = multi_hot;
          if (exp_q.size() == 0) begin
            check("spurious_event", 1, 0);
          end else begin
            e = exp_q.pop_front();
            check("ev_code", y_code, e.code);
            check("ev_multi", multi_hot, e.multi);
            check("ev_cycle", cyc, e.cyc);
          end
        end
        prev_valid = y_valid;
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_rise(input int limit);
    int s;
    s = n_rise;
    for (int i = 0; i < limit && n_rise == s; i++) @(negedge clk);
    check("rise_timeout", int'(n_rise != s), 1);
  endtask

  task automatic idle_out();
    d = 4'd0;
    y_ready = 1'b1;
    cycles(STABLE + LAT + 4);
  endtask

  int base, ev0;

  initial begin
    rst_n = 1'b0; d = 4'd0; y_ready = 1'b1;
    #1;
    check("rst_valid", y_valid, 0);
    check("rst_code", y_code, 0);
    check("rst_multi", multi_hot, 0);
    cycles(2);
    rst_n = 1'b1;
    cycles(1);

    // Simple press with latency check
    d = 4'b0100; base = cyc; ev0 = n_rise;
    cycles(RISE + 4);
    check("press_events", n_rise - ev0, 1);
    check("press_latency", last_rise_cyc - base, RISE);
    check("press_code", last_code, 2);
    check("press_multi", last_multi, 0);
    idle_out();

    // Bounce 0010 -> 0100
    ev0 = n_rise;
    d = 4'b0010; cycles(2);
    d = 4'b0100; cycles(RISE + 6);
    check("bounce_events", n_rise - ev0, 1);
    check("bounce_code", last_code, 2);
    idle_out();

    // Multi-hot
    d = 4'b1010; cycles(RISE + 4);
    check("multi_code", last_code, 3);
    check("multi_flag", last_multi, 1);
    idle_out();

    // Backpressure
    y_ready = 1'b0; ev0 = n_rise;
    d = 4'b0100;
    wait_rise(RISE + 4);
    d = 4'b0001;
    cycles(10);
    check("bp_valid", y_valid, 1);
    check("bp_code", y_code, 2);
    check("bp_multi", multi_hot, 0);
    y_ready = 1'b1;
    cycles(12);
    check("bp_no_second", n_rise - ev0, 1);
    check("bp_code_kept", y_code, 2);
    idle_out();

    // Release / repeat
    ev0 = n_rise;
    d = 4'b0001; cycles(50);
    check("hold50_events", n_rise - ev0, 1);
    d = 4'd0; cycles(3);
    d = 4'b0001; cycles(12);
    check("short_release", n_rise - ev0, 1);
    d = 4'd0; cycles(4);
    d = 4'b0001; cycles(RISE + 4);
    check("full_release", n_rise - ev0, 2);
    idle_out();

    // Asynchronous reset while holding
    y_ready = 1'b0;
    d = 4'b1000;
    wait_rise(RISE + 4);
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid", y_valid, 0);
    check("arst_code", y_code, 0);
    check("arst_multi", multi_hot, 0);
    cycles(2);
    rst_n = 1'b1; base = cyc; ev0 = n_rise;
    cycles(RISE + 3);
    check("post_rst_events", n_rise - ev0, 1);
    check("post_rst_latency", last_rise_cyc - base, RISE);
    y_ready = 1'b1;
    idle_out();

    // Randomized traffic
    for (int k = 0; k < 300; k++) begin
      int hold;
      d = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
      hold = $urandom_range(1, 10);
      for (int j = 0; j < hold; j++) begin
        y_ready = ($urandom_range(0, 3) != 0);
        cycles(1);
      end
    end

    idle_out();
    cycles(4);
    check("pending_events", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
